// File: rtl/fp_adder_arbiter.sv
// fp_adder_arbiter: round-robin share of one 9-bit fp_adder (1.4.4, bias 7) across NUM_REQ lanes.
// Accept at edge N gives rsp_valid after N+1; a stalled response holds stage 2, stage 1 refills once, then req_ready drops.

module fp_adder (
   input  logic [8:0] a,
   input  logic [8:0] b,
   input  logic       sub,
   output logic [8:0] result,
   output logic       overflow,
   output logic       underflow,
   output logic       zero_detect
);
   logic       b_sign;
   logic       a_big;
   logic       big_s;
   logic       small_s;
   logic [3:0] big_e;
   logic [3:0] small_e;
   logic [3:0] exp_diff;
   logic [3:0] big_f;
   logic [7:0] big_m;
   logic [7:0] small_m;
   logic [7:0] small_al;
   logic [8:0] sum;
   logic [7:0] norm;
   logic       found;
   int         lz;
   int         exp_res;

   always_comb begin
      // Exponent 0 encodes zero (no denormals); mantissas carry 3 guard bits, result truncates.
      b_sign   = b[8] ^ sub;
      a_big    = a[7:0] >= b[7:0];
      big_s    = a_big ? a[8]   : b_sign;
      small_s  = a_big ? b_sign : a[8];
      big_e    = a_big ? a[7:4] : b[7:4];
      small_e  = a_big ? b[7:4] : a[7:4];
      big_f    = a_big ? a[3:0] : b[3:0];
      big_m    = {big_e != 4'd0, big_f, 3'b000};
      small_m  = a_big ? {b[7:4] != 4'd0, b[3:0], 3'b000} : {a[7:4] != 4'd0, a[3:0], 3'b000};
      exp_diff = big_e - small_e;
      small_al = small_m >> exp_diff;

      if (big_s == small_s) begin
         sum = {1'b0, big_m} + {1'b0, small_al};
      end else begin
         sum = {1'b0, big_m} - {1'b0, small_al};
      end

      lz    = 0;
      found = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (!found && !sum[i]) begin
            lz = lz + 1;
         end else begin
            found = 1'b1;
         end
      end

      if (sum[8]) begin
         norm    = sum[8:1];
         exp_res = int'(big_e) + 1;
      end else begin
         norm    = sum[7:0] << lz;
         exp_res = int'(big_e) - lz;
      end

      result      = 9'd0;
      overflow    = 1'b0;
      underflow   = 1'b0;
      zero_detect = 1'b0;
      if (norm == 8'd0) begin
         zero_detect = 1'b1;
      end else if (exp_res >= 15) begin
         // Out of range: pass the larger-magnitude operand through and flag it.
         overflow = 1'b1;
         result   = {big_s, big_e, big_f};
      end else if (exp_res <= 0) begin
         underflow   = 1'b1;
         zero_detect = 1'b1;
      end else begin
         result = {big_s, exp_res[3:0], norm[6:3]};
      end
   end
endmodule

module fp_adder_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ),
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ*9-1:0] req_operand_a,
   input  logic [NUM_REQ*9-1:0] req_operand_b,
   input  logic [NUM_REQ-1:0]   req_subtract,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [8:0]           rsp_result,
   output logic                 rsp_overflow,
   output logic                 rsp_underflow,
   output logic                 rsp_zero_detect,
   output logic                 sticky_overflow,
   output logic                 sticky_underflow,
   input  logic                 sticky_clear,
   output logic [CNT_W-1:0]     op_count
);
   typedef struct packed {
      logic [8:0]      a;
      logic [8:0]      b;
      logic            sub;
      logic [ID_W-1:0] id;
   } op_t;

   typedef struct packed {
      logic [8:0]      result;
      logic            ovf;
      logic            unf;
      logic            zero;
      logic [ID_W-1:0] id;
   } rsp_t;

   op_t             s1_q, s1_d;
   logic            s1_valid_q, s1_valid_d;
   rsp_t            s2_q, s2_d;
   logic            s2_valid_q, s2_valid_d;
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic            sticky_ovf_q, sticky_ovf_d;
   logic            sticky_unf_q, sticky_unf_d;
   logic [CNT_W-1:0] op_cnt_q, op_cnt_d;

   logic            grant_vld;
   logic [ID_W-1:0] grant;
   int              scan_idx;
   int              gi;
   logic            s2_free;
   logic            s1_adv;
   logic            s1_can_accept;
   logic            accept;
   logic            xfer;
   logic [8:0]      add_result;
   logic            add_ovf;
   logic            add_unf;
   logic            add_zero;

   fp_adder u_fp_adder (
      .a           (s1_q.a),
      .b           (s1_q.b),
      .sub         (s1_q.sub),
      .result      (add_result),
      .overflow    (add_ovf),
      .underflow   (add_unf),
      .zero_detect (add_zero)
   );

   // First valid requester at or after the pointer, wrapping.
   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      scan_idx  = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = (int'(ptr_q) + k) % NUM_REQ;
         if (!grant_vld && req_valid[scan_idx]) begin
            grant_vld = 1'b1;
            grant     = ID_W'(scan_idx);
         end
      end
   end

   always_comb begin
      s2_free       = !s2_valid_q || rsp_ready;
      s1_adv        = s1_valid_q && s2_free;
      s1_can_accept = !s1_valid_q || s1_adv;
      accept        = grant_vld && s1_can_accept;
      xfer          = s2_valid_q && rsp_ready;
      gi            = int'(grant);

      req_ready = '0;
      if (accept) begin
         req_ready[grant] = 1'b1;
      end

      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      ptr_d      = ptr_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_d.a     = req_operand_a[gi*9 +: 9];
         s1_d.b     = req_operand_b[gi*9 +: 9];
         s1_d.sub   = req_subtract[gi];
         s1_d.id    = grant;
         ptr_d      = (gi == NUM_REQ - 1) ? '0 : ID_W'(gi + 1);
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      s2_valid_d = s2_valid_q;
      s2_d       = s2_q;
      if (s1_adv) begin
         s2_valid_d  = 1'b1;
         s2_d.result = add_result;
         s2_d.ovf    = add_ovf;
         s2_d.unf    = add_unf;
         s2_d.zero   = add_zero;
         s2_d.id     = s1_q.id;
      end else if (xfer) begin
         s2_valid_d = 1'b0;
      end

      // A flagged transfer on the same edge as a clear keeps the flag set.
      sticky_ovf_d = (sticky_ovf_q && !sticky_clear) || (xfer && s2_q.ovf);
      sticky_unf_d = (sticky_unf_q && !sticky_clear) || (xfer && s2_q.unf);

      op_cnt_d = op_cnt_q;
      if (xfer && (op_cnt_q != {CNT_W{1'b1}})) begin
         op_cnt_d = op_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q         <= '0;
         s1_valid_q   <= 1'b0;
         s2_q         <= '0;
         s2_valid_q   <= 1'b0;
         ptr_q        <= '0;
         sticky_ovf_q <= 1'b0;
         sticky_unf_q <= 1'b0;
         op_cnt_q     <= '0;
      end else begin
         s1_q         <= s1_d;
         s1_valid_q   <= s1_valid_d;
         s2_q         <= s2_d;
         s2_valid_q   <= s2_valid_d;
         ptr_q        <= ptr_d;
         sticky_ovf_q <= sticky_ovf_d;
         sticky_unf_q <= sticky_unf_d;
         op_cnt_q     <= op_cnt_d;
      end
   end

   assign rsp_valid        = s2_valid_q;
   assign rsp_id           = s2_q.id;
   assign rsp_result       = s2_q.result;
   assign rsp_overflow     = s2_q.ovf;
   assign rsp_underflow    = s2_q.unf;
   assign rsp_zero_detect  = s2_q.zero;
   assign sticky_overflow  = sticky_ovf_q;
   assign sticky_underflow = sticky_unf_q;
   assign op_count         = op_cnt_q;

   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
   a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(s2_q)));
endmodule

// File: doc/fp_adder_arbiter.md
Name: fp_adder_arbiter

Overview:
Shares one fp_adder instance (9-bit format: sign, 4-bit exponent, 4-bit fraction) between NUM_REQ requesters. The block does the following:
- Round-robin arbitration.
- A two-stage registered pipeline: operand register, then response register.
- A single valid/ready response channel that carries the requester ID.
- Sticky exception flags and an operation counter for status readout.

It sits between the per-lane producers and the shared adder datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of the requester ID
CNT_W, 16, width of the saturating operation counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
req_operand_a  input  NUM_REQ*9  operand A of requester i in bits [9i+8:9i]
req_operand_b  input  NUM_REQ*9  operand B of requester i in bits [9i+8:9i]
req_subtract  input  NUM_REQ  1 = A-B, 0 = A+B
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accept
rsp_id  output  ID_W  index of the requester that owns the response
rsp_result  output  9  adder result
rsp_overflow  output  1  adder overflow for this op
rsp_underflow  output  1  adder underflow for this op
rsp_zero_detect  output  1  adder zero flag for this op
sticky_overflow  output  1  set by any response with overflow
sticky_underflow  output  1  set by any response with underflow
sticky_clear  input  1  synchronous clear of both sticky flags
op_count  output  CNT_W  number of responses delivered, saturating

Behaviour:
Reset (rst_n low, asynchronous): the following all go to 0:
- s1_valid, s2_valid, rsp_valid.
- rsp_id, rsp_result and all rsp_* flags.
- Both sticky flags and op_count.
- The round-robin pointer.

Pipeline stages:
- Stage 1 (operand register) holds a_reg, b_reg, sub_reg, id_reg and s1_valid. The fp_adder is driven combinationally from stage 1.
- Stage 2 (response register) holds rsp_* and s2_valid, which drives rsp_valid.

Advance conditions:
- s2_free = !s2_valid || rsp_ready.
- s1_adv = s1_valid && s2_free.
- s1_can_accept = !s1_valid || s1_adv.
- Note: this gives a combinational path from rsp_ready to req_ready. This is intended.

Arbitration:
- The arbiter is combinational. It scans req_valid starting at the pointer index, wrapping modulo NUM_REQ. The first valid index is the grant g.
- req_ready[g] = s1_can_accept. All other req_ready bits are 0.
- If no req_valid is set, req_ready is all zero.

Accept (req_valid[g] && req_ready[g] at edge N):
- Stage 1 loads requester g's operands and ID.
- pointer <= (g+1) mod NUM_REQ.
- The pointer is unchanged on cycles with no accept.

Latency:
- Accepted at edge N gives a result captured at edge N+1, with rsp_valid high after N+1 if stage 2 was free.
- Peak throughput is 1 op per cycle.

Stage 2 load: on s1_adv, stage 2 captures fp_adder result/overflow/underflow/zero_detect and id_reg, and s2_valid goes to 1.
- If s1_adv does not occur and rsp_ready && s2_valid, then s2_valid goes to 0.
- Stage 1 clears when s1_adv && no new accept in the same cycle.

Backpressure:
- While rsp_valid && !rsp_ready, all rsp_* outputs are held stable.
- Stage 1 holds. At most one further request can be accepted, and only while stage 1 is empty.

Requester rules:
- A requester keeps req_valid and its operands stable until accepted.
- Dropping valid before accept is allowed; the arbiter simply skips that requester.

Response transfer: a response is delivered on rsp_valid && rsp_ready. At that edge:
- op_count increments, saturating at all-ones.
- sticky_overflow |= rsp_overflow.
- sticky_underflow |= rsp_underflow.

sticky_clear:
- Clears both sticky flags on the edge.
- If it coincides with a flagged transfer, the set wins.

Ordering: responses are delivered strictly in acceptance order.

Reset mid-operation: in-flight ops are discarded, no response is produced, and the pointer returns to 0.

Test Plan:
- Single request: req 0, A=9'h070, B=9'h070, sub=0 accepted at edge N -> rsp_valid after N+1 with rsp_id=0, rsp_result=9'h080, all flags 0, op_count=1.
- Zero result: req 2, A=B=9'h070, sub=1 -> rsp_result=9'h000, rsp_zero_detect=1, rsp_id=2.
- Round-robin: all 4 requesters hold valid continuously with rsp_ready=1 -> accept order 0,1,2,3,0,1; one accept per cycle; responses arrive in the same ID order.
- Backpressure: rsp_ready=0 for 5 cycles while requests 1 and 3 are pending -> exactly 2 ops in flight; rsp_* stable; req_ready all zero after the second accept; on release, responses for IDs 1 then 3 on consecutive cycles.
- Overflow and sticky: A=B=9'h0E0, sub=0 -> rsp_result=9'h0E0, rsp_overflow=1, sticky_overflow=1. A later clean op leaves sticky_overflow at 1. Asserting sticky_clear clears it. sticky_clear together with an overflow transfer leaves it at 1.
- Reset mid-op: assert rst_n=0 with stage 1 and stage 2 both valid -> rsp_valid=0 immediately, op_count=0, pointer=0. After release with all valid, requester 0 is granted first.
